// File: rtl/even_par_gen_tx.sv
// rtl/even_par_gen_tx.sv - serial transmitter framing a word as start, data LSB first, even parity, stop
module even_par_gen_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              parity_out,
    output logic              frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              ready_q, ready_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end = (timer_q == TIMER_LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        // The timer only runs inside a frame; every bit-end resets it for the next bit.
        if (state_q != S_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (ready_q && data_valid) begin
                    state_d  = S_START;
                    shift_d  = data_in;
                    parity_d = ^data_in;
                    timer_d  = '0;
                    idx_d    = '0;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            ready_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_ready = ready_q;
    assign tx_serial  = tx_q;
    assign tx_busy    = busy_q;
    assign parity_out = parity_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_even_par_gen_tx.sv
// tb/tb_even_par_gen_tx.sv - scoreboard bench for even_par_gen_tx at one and four clocks per bit
module tb_even_par_gen_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic go = 1'b0;
    logic abort_done = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Line level at cycle k of a frame carrying w: start, four data bits LSB first, even parity, stop.
    function automatic logic exp_line(input logic [3:0] w, input int k, input int c);
        int b;
        b = k / c;
        if (b == 0) return 1'b0;
        if (b <= 4) return w[b-1];
        if (b == 5) return logic'($countones(w) % 2);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int C = (g == 0) ? 1 : 4;
        logic [3:0] din;
        logic dv, dr, txs, busy, par, fd;
        logic [3:0] exp_q[$];
        logic done = 1'b0;
        logic abort_go = 1'b0;

        even_par_gen_tx #(.DATA_W(4), .CLKS_PER_BIT(C)) dut (
            .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv),
            .data_ready(dr), .tx_serial(txs), .tx_busy(busy),
            .parity_out(par), .frame_done(fd)
        );

        // Driver: 16-word sweep then random words, random gaps or back-to-back with garbage mid-frame.
        initial begin
            logic [3:0] w;
            int guard;
            din = '0;
            dv  = 1'b0;
            wait (go);
            for (int n = 0; n < 40; n++) begin
                w = (n < 16) ? 4'(n) : 4'($urandom);
                guard = 0;
                @(negedge clk);
                dv = 1'b1;
                while (!dr && guard < 200) begin
                    din = 4'($urandom);
                    guard++;
                    @(negedge clk);
                end
                if (guard >= 200) check("accept_timeout", 0, 1);
                din = w;
                exp_q.push_back(w);
                @(posedge clk);
                if ($urandom_range(0, 2) != 0) begin
                    @(negedge clk);
                    dv = 1'b0;
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                end
            end
            @(negedge clk);
            dv = 1'b0;
            for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
            if (g == 1) begin
                done = 1'b1;
                @(negedge clk);
                dv  = 1'b1;
                din = 4'b1110;
                guard = 0;
                while (!dr && guard < 200) begin
                    guard++;
                    @(negedge clk);
                end
                @(posedge clk);
                abort_go = 1'b1;
                wait (abort_done);
                dv = 1'b0;
            end else begin
                done = 1'b1;
            end
        end

        // Monitor: collect the line while busy, compare on frame_done against the queued word.
        initial begin
            logic [63:0] samp, expv;
            logic [3:0] w, rx;
            logic pb, prev_busy;
            int k;
            k = 0;
            samp = '0;
            prev_busy = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    k = 0;
                    samp = '0;
                end else begin
                    if (busy) begin
                        if (k < 64) samp[k] = txs;
                        k++;
                    end
                    if (fd) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_frame_done", 1, 0);
                        end else begin
                            w = exp_q.pop_front();
                            expv = '0;
                            for (int i = 0; i < 7 * C; i++) expv[i] = exp_line(w, i, C);
                            check("frame_bits", samp, expv);
                            check("busy_cycles", k, 7 * C);
                            check("parity_out", par, $countones(w) % 2);
                            check("done_after_busy", prev_busy, 1);
                            check("done_cycle_idle", {txs, busy, dr}, 3'b101);
                            for (int i = 0; i < 4; i++) rx[i] = samp[(i + 1) * C + C / 2];
                            pb = samp[5 * C + C / 2];
                            check("loopback_data", rx, w);
                            check("loopback_parity", ($countones(rx) + pb) % 2, 0);
                        end
                        k = 0;
                        samp = '0;
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_l0", {lane[0].txs, lane[0].dr, lane[0].busy, lane[0].par, lane[0].fd}, 5'b10000);
        check("reset_outs_l1", {lane[1].txs, lane[1].dr, lane[1].busy, lane[1].par, lane[1].fd}, 5'b10000);
        #1 rst_n = 1'b1;
        #1 check("ready_before_edge", lane[0].dr, 0);
        @(negedge clk);
        check("ready_after_release_l0", lane[0].dr, 1);
        check("ready_after_release_l1", lane[1].dr, 1);
        go = 1'b1;

        for (int t = 0; t < 20000 && !(lane[0].done && lane[1].done); t++) @(negedge clk);
        check("drivers_finished", lane[0].done && lane[1].done, 1);
        check("queue_drained_l0", lane[0].exp_q.size(), 0);

        for (int t = 0; t < 300 && !lane[1].abort_go; t++) @(negedge clk);
        check("abort_word_accepted", lane[1].abort_go, 1);
        // Seventh cycle after acceptance at four clocks per bit sits in data bit 0.
        repeat (6) @(negedge clk);
        check("pre_abort_in_data", {lane[1].busy, lane[1].txs}, 2'b10);
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {lane[1].txs, lane[1].dr, lane[1].busy, lane[1].par, lane[1].fd}, 5'b10000);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", {lane[1].fd, lane[1].busy}, 2'b00);
        end
        rst_n = 1'b1;
        abort_done = 1'b1;
        #1 check("ready_low_at_release", lane[1].dr, 0);
        @(negedge clk);
        check("ready_after_abort", {lane[1].dr, lane[1].busy, lane[1].fd}, 3'b100);
        @(negedge clk);
        check("no_accept_from_reset", {lane[1].busy, lane[1].fd}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
